// File: rtl/ray_march_controller.sv
// Ray-march initiator: walks one ray voxel by voxel, querying occupancy and
// calling the AABB stepper until a hit, a grid exit, or the step budget runs out.
module ray_march_controller #(
   parameter int WIDTH      = 16,
   parameter int VOXEL_BITS = 4,
   parameter int MAX_STEPS  = 64
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                start,
   input  logic [3*WIDTH-1:0]                  q,
   input  logic [3*WIDTH-1:0]                  v,
   output logic                                ready,
   output logic                                done,
   output logic                                hit,
   output logic                                timeout,
   output logic [3*WIDTH-1:0]                  hit_pos,
   output logic [$clog2(MAX_STEPS+1)-1:0]      steps,
   output logic                                mem_req,
   output logic [3*(WIDTH-VOXEL_BITS)-1:0]     mem_addr,
   input  logic                                mem_valid,
   input  logic                                mem_occupied,
   output logic                                step_start,
   output logic [3*WIDTH-1:0]                  step_q,
   output logic [3*WIDTH-1:0]                  step_v,
   output logic [3*WIDTH-1:0]                  step_l,
   output logic [3*WIDTH-1:0]                  step_u,
   input  logic                                step_done,
   input  logic                                step_oob,
   input  logic [3*WIDTH-1:0]                  step_vp
);

   localparam int IW = WIDTH - VOXEL_BITS;
   localparam int SW = $clog2(MAX_STEPS + 1);
   localparam logic signed [WIDTH-1:0] SZERO = '0;

   typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_MEM, STEP, WAIT_STEP, DONE} state_t;

   state_t              state, state_nxt;
   logic [3*WIDTH-1:0]  pos, pos_nxt, dir;
   logic [3*WIDTH-1:0]  box_l, box_u, nudged;
   logic [2:0]          wraps;
   logic [WIDTH:0]      nr;
   logic [SW-1:0]       step_cnt;
   logic                fin_hit, fin_to, accept;

   // Push an exit point that sits on the face the ray leaves through into the
   // neighbouring voxel; the top bit reports wrap-around past the grid edge.
   function automatic logic [WIDTH:0] nudge(input logic [WIDTH-1:0] vp,
                                            input logic [WIDTH-1:0] l,
                                            input logic [WIDTH-1:0] u,
                                            input logic signed [WIDTH-1:0] d);
      logic [WIDTH:0] r;
      r = {1'b0, vp};
      if (vp == u && d > SZERO)
         r = {1'b0, vp} + (WIDTH+1)'(1);
      else if (vp == l && d < SZERO)
         r = {1'b0, vp} - (WIDTH+1)'(1);
      return r;
   endfunction

   always_comb begin
      mem_addr = '0;
      box_l    = '0;
      box_u    = '0;
      nudged   = '0;
      wraps    = '0;
      nr       = '0;
      for (int i = 0; i < 3; i++) begin
         mem_addr[i*IW +: IW]   = pos[i*WIDTH+VOXEL_BITS +: IW];
         box_l[i*WIDTH +: WIDTH] = {pos[i*WIDTH+VOXEL_BITS +: IW], {VOXEL_BITS{1'b0}}};
         box_u[i*WIDTH +: WIDTH] = {pos[i*WIDTH+VOXEL_BITS +: IW], {VOXEL_BITS{1'b1}}};
         nr = nudge(step_vp[i*WIDTH +: WIDTH], step_l[i*WIDTH +: WIDTH],
                    step_u[i*WIDTH +: WIDTH], dir[i*WIDTH +: WIDTH]);
         nudged[i*WIDTH +: WIDTH] = nr[WIDTH-1:0];
         wraps[i] = nr[WIDTH];
      end
   end

   always_comb begin
      state_nxt  = state;
      pos_nxt    = pos;
      fin_hit    = 1'b0;
      fin_to     = 1'b0;
      ready      = (state == IDLE) || (state == DONE);
      done       = (state == DONE);
      mem_req    = (state == LOOKUP);
      step_start = (state == STEP);
      accept     = ready && start;
      case (state)
         IDLE:     if (start) state_nxt = LOOKUP;
         LOOKUP:   state_nxt = WAIT_MEM;
         WAIT_MEM: if (mem_valid) begin
            if (mem_occupied) begin
               fin_hit   = 1'b1;
               state_nxt = DONE;
            end else if (dir == '0) begin
               state_nxt = DONE;
            end else begin
               state_nxt = STEP;
            end
         end
         STEP:     state_nxt = WAIT_STEP;
         WAIT_STEP: if (step_done) begin
            if (step_oob) begin
               state_nxt = DONE;
            end else if (wraps != 3'b000) begin
               pos_nxt   = step_vp;
               state_nxt = DONE;
            end else begin
               pos_nxt = nudged;
               if (step_cnt == SW'(MAX_STEPS)) begin
                  fin_to    = 1'b1;
                  state_nxt = DONE;
               end else begin
                  state_nxt = LOOKUP;
               end
            end
         end
         DONE:     state_nxt = start ? LOOKUP : IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= IDLE;
         pos      <= '0;
         dir      <= '0;
         step_cnt <= '0;
         step_q   <= '0;
         step_v   <= '0;
         step_l   <= '0;
         step_u   <= '0;
         hit      <= 1'b0;
         timeout  <= 1'b0;
         hit_pos  <= '0;
         steps    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            pos      <= q;
            dir      <= v;
            step_cnt <= '0;
            hit      <= 1'b0;
            timeout  <= 1'b0;
         end else begin
            pos <= pos_nxt;
         end
         // Stepper operands are frozen on entry to STEP and held until step_done.
         if (state == WAIT_MEM && state_nxt == STEP) begin
            step_q <= pos;
            step_v <= dir;
            step_l <= box_l;
            step_u <= box_u;
         end
         if (state == STEP)
            step_cnt <= step_cnt + SW'(1);
         if (state_nxt == DONE && state != DONE) begin
            hit     <= fin_hit;
            timeout <= fin_to;
            hit_pos <= pos_nxt;
            steps   <= step_cnt;
         end
      end
   end

endmodule

// File: tb/tb_ray_march_controller.sv
// Directed bench for ray_march_controller with behavioural occupancy memory
// and axis-aligned stepper models.
module tb_ray_march_controller;

   localparam int W  = 16;
   localparam int VB = 4;
   localparam int MS = 4;
   localparam int SW = $clog2(MS + 1);
   localparam int AW = 3 * (W - VB);

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic [3*W-1:0] q = '0, v = '0;
   logic ready, done, hit, timeout, mem_req, step_start;
   logic [3*W-1:0] hit_pos, step_q, step_v, step_l, step_u;
   logic [SW-1:0] steps;
   logic [AW-1:0] mem_addr;
   logic mem_valid = 1'b0, mem_occupied = 1'b0;
   logic step_done = 1'b0, step_oob = 1'b0;
   logic [3*W-1:0] step_vp = '0;

   logic occ_en = 1'b0, oob_mode = 1'b0;
   logic [AW-1:0] occ_addr = '0;

   int n_chk = 0, n_fail = 0;
   int n_mreq = 0, n_sstart = 0, n_done = 0;
   logic [AW-1:0] last_addr = '0;

   always #5 clock = ~clock;

   ray_march_controller #(.WIDTH(W), .VOXEL_BITS(VB), .MAX_STEPS(MS)) dut (
      .clock(clock), .reset(reset), .start(start), .q(q), .v(v),
      .ready(ready), .done(done), .hit(hit), .timeout(timeout),
      .hit_pos(hit_pos), .steps(steps),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_valid(mem_valid), .mem_occupied(mem_occupied),
      .step_start(step_start), .step_q(step_q), .step_v(step_v),
      .step_l(step_l), .step_u(step_u),
      .step_done(step_done), .step_oob(step_oob), .step_vp(step_vp)
   );

   // Occupancy memory: two-cycle latency, one occupied voxel when enabled.
   logic m1 = 1'b0;
   logic [AW-1:0] a1 = '0;
   always @(posedge clock) begin
      m1           <= mem_req;
      a1           <= mem_addr;
      mem_valid    <= m1;
      mem_occupied <= m1 && occ_en && (a1 == occ_addr);
   end

   // Stepper: exits through the u face for positive axes, l face for negative.
   logic [1:0] scnt = '0;
   logic [3*W-1:0] sq = '0, sv = '0, sl = '0, su = '0;
   function automatic logic [3*W-1:0] exit_pt(input logic [3*W-1:0] pq, pv, pl, pu);
      logic [3*W-1:0] r;
      logic [W-1:0] d;
      r = '0;
      for (int i = 0; i < 3; i++) begin
         d = pv[i*W +: W];
         if (d == '0)        r[i*W +: W] = pq[i*W +: W];
         else if (d[W-1])    r[i*W +: W] = pl[i*W +: W];
         else                r[i*W +: W] = pu[i*W +: W];
      end
      return r;
   endfunction

   always @(posedge clock) begin
      step_done <= 1'b0;
      step_oob  <= 1'b0;
      if (step_start) begin
         scnt <= 2'd3;
         sq <= step_q; sv <= step_v; sl <= step_l; su <= step_u;
      end else if (scnt != 2'd0) begin
         scnt <= scnt - 2'd1;
         if (scnt == 2'd1) begin
            step_done <= 1'b1;
            step_oob  <= oob_mode;
            step_vp   <= exit_pt(sq, sv, sl, su);
         end
      end
   end

   always @(posedge clock) begin
      if (mem_req) begin
         n_mreq    <= n_mreq + 1;
         last_addr <= mem_addr;
      end
      if (step_start) n_sstart <= n_sstart + 1;
      if (done)       n_done   <= n_done + 1;
   end

   function automatic logic [3*W-1:0] pk(input int x, input int y, input int z);
      return {W'(z), W'(y), W'(x)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3*W-1:0] q, v;
      logic           occ_en;
      logic [AW-1:0]  occ_addr;
      logic           oob;
      logic           hit, to;
      logic [3*W-1:0] pos;
      int             steps, nreq, nstep;
      logic [AW-1:0]  addr;
   } vec_t;

   vec_t tbl[7];

   task automatic wait_done(input string tag);
      logic got;
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         if (done) got = 1'b1;
         else @(negedge clock);
      end
      chk({tag, "_done_seen"}, 64'(got), 64'd1);
   endtask

   task automatic run_vec(input int i);
      int br, bs;
      occ_en = tbl[i].occ_en; occ_addr = tbl[i].occ_addr; oob_mode = tbl[i].oob;
      br = n_mreq; bs = n_sstart;
      q = tbl[i].q; v = tbl[i].v; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_hit", i),     64'(hit),           64'(tbl[i].hit));
      chk($sformatf("v%0d_timeout", i), 64'(timeout),       64'(tbl[i].to));
      chk($sformatf("v%0d_pos", i),     64'(hit_pos),       64'(tbl[i].pos));
      chk($sformatf("v%0d_steps", i),   64'(steps),         64'(tbl[i].steps));
      chk($sformatf("v%0d_nreq", i),    64'(n_mreq - br),   64'(tbl[i].nreq));
      chk($sformatf("v%0d_nstep", i),   64'(n_sstart - bs), 64'(tbl[i].nstep));
      chk($sformatf("v%0d_addr", i),    64'(last_addr),     64'(tbl[i].addr));
      @(negedge clock);
      chk($sformatf("v%0d_pulse", i),   64'({done, ready}), 64'b01);
      chk($sformatf("v%0d_hold", i),    64'(hit_pos),       64'(tbl[i].pos));
   endtask

   initial begin
      int bd, br;
      logic seen;
      tbl[0] = '{pk(5,5,5),     pk(1,0,0),      1'b1, AW'(0), 1'b0, 1'b1, 1'b0, pk(5,5,5),      0, 1, 0, AW'(0)};
      tbl[1] = '{pk(5,5,5),     pk(1,0,0),      1'b1, AW'(1), 1'b0, 1'b1, 1'b0, pk(16,5,5),     1, 2, 1, AW'(1)};
      tbl[2] = '{pk(40,8,8),    pk(16'hFFFF,0,0), 1'b0, AW'(0), 1'b0, 1'b0, 1'b0, pk(0,8,8),    3, 3, 3, AW'(0)};
      tbl[3] = '{pk(5,5,5),     pk(1,0,0),      1'b0, AW'(0), 1'b0, 1'b0, 1'b1, pk(64,5,5),     4, 4, 4, AW'(3)};
      tbl[4] = '{pk(100,200,300), pk(1,1,0),    1'b0, AW'(0), 1'b1, 1'b0, 1'b0, pk(100,200,300), 1, 1, 1,
                 {12'd18, 12'd12, 12'd6}};
      tbl[5] = '{pk(7,7,7),     pk(0,0,0),      1'b0, AW'(0), 1'b0, 1'b0, 1'b0, pk(7,7,7),      0, 1, 0, AW'(0)};
      tbl[6] = '{pk(16'hFFF0,3,3), pk(1,0,0),   1'b0, AW'(0), 1'b0, 1'b0, 1'b0, pk(16'hFFFF,3,3), 1, 1, 1,
                 {12'd0, 12'd0, 12'hFFF}};

      repeat (3) @(negedge clock);
      chk("rst_ready",   64'(ready), 64'd1);
      chk("rst_pulses",  64'({done, mem_req, step_start, hit, timeout}), 64'd0);
      chk("rst_hit_pos", 64'(hit_pos), 64'd0);
      chk("rst_steps",   64'(steps), 64'd0);
      chk("rst_addr",    64'(mem_addr), 64'd0);
      chk("rst_step_u",  64'(step_u), 64'd0);
      reset = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 7; i++) run_vec(i);

      // Reset while waiting on the stepper; the late step_done must be ignored.
      occ_en = 1'b0; oob_mode = 1'b0;
      q = pk(5,5,5); v = pk(1,0,0); start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         if (step_start) seen = 1'b1;
         else @(negedge clock);
      end
      chk("rr_step_start_seen", 64'(seen), 64'd1);
      chk("rr_step_l", 64'(step_l), 64'(pk(0,0,0)));
      chk("rr_step_u", 64'(step_u), 64'(pk(15,15,15)));
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      chk("rr_ready", 64'(ready), 64'd1);
      bd = n_done; br = n_mreq;
      repeat (10) @(negedge clock);
      chk("rr_no_done",  64'(n_done - bd), 64'd0);
      chk("rr_no_req",   64'(n_mreq - br), 64'd0);
      chk("rr_idle",     64'(ready), 64'd1);
      run_vec(1);

      // A start pulsed while busy must not disturb the ray in flight.
      occ_en = 1'b1; occ_addr = AW'(1); oob_mode = 1'b0;
      q = pk(5,5,5); v = pk(1,0,0); start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      q = pk(100,100,100); start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done("busy");
      chk("busy_pos",   64'(hit_pos), 64'(pk(16,5,5)));
      chk("busy_steps", 64'(steps), 64'd1);
      chk("busy_hit",   64'(hit), 64'd1);
      repeat (2) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
